mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch and load/store data access.
//  Sits between the PC/fetch logic, the load/store path and the memory macro.
//  Serialises requests, one outstanding transaction at a time.
//  Raises stall to freeze the PC and register-file write while an access is pending.
// PARAMETERS
//  WIDTH  32  data and address width in bits
//  BE_W   4   byte-enable width; must equal WIDTH/8
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  if_req     in   1      fetch request; held with if_addr until if_rvalid
//  if_addr    in   WIDTH  fetch address, word-aligned
//  if_gnt     out  1      1-cycle pulse: fetch request captured
//  if_rvalid  out  1      1-cycle pulse: if_rdata valid
//  if_rdata   out  WIDTH  fetched instruction
//  d_req      in   1      data request; held with its fields until d_done
//  d_we       in   1      1 = store, 0 = load
//  d_addr     in   WIDTH  data address, word-aligned
//  d_wdata    in   WIDTH  store data
//  d_be       in   BE_W   byte enables, for stores only
//  d_gnt      out  1      1-cycle pulse: data request captured
//  d_done     out  1      1-cycle pulse: load data valid, or store acknowledged
//  d_rdata    out  WIDTH  load data
//  m_req      out  1      memory request; held until m_gnt
//  m_we       out  1      memory write enable
//  m_addr     out  WIDTH  memory address
//  m_wdata    out  WIDTH  memory write data
//  m_be       out  BE_W   memory byte enables; all ones on reads
//  m_gnt      in   1      memory accepted the request
//  m_rvalid   in   1      memory response: read data, or write ack; never in the same cycle as m_gnt
//  m_rdata    in   WIDTH  memory read data
//  stall      out  1      (if_req & ~if_rvalid) | (d_req & ~d_done); combinational
// BEHAVIOUR
//  FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
//  IDLE:
//   - d_req set: latch the data fields, pulse d_gnt, go to REQ_D.
//   - else if_req set: latch if_addr, pulse if_gnt, go to REQ_I.
//   - both set: data wins. Fetch stays pending and is taken at the next IDLE.
//  REQ_x:
//   - m_req=1, all m_* driven from the latched fields (registered; stable while waiting).
//   - On m_gnt go to WAIT_x. m_req deasserts in the WAIT state.
//  WAIT_x:
//   - On m_rvalid pulse if_rvalid or d_done, go to IDLE.
//   - x_rdata = m_rdata in that cycle, combinational pass-through; 0 otherwise.
//  Minimum latency, req to response: 3 cycles (IDLE capture, REQ with same-cycle m_gnt, WAIT with m_rvalid).
//  m_rvalid outside WAIT_x is ignored. No timeout: WAIT holds indefinitely.
//  Requester dropping req after gnt does not cancel the transaction; the response still pulses.
//  A new request is never captured in the cycle the previous response pulses; it is captured at the next IDLE cycle.
//  Reset (any cycle, including mid-transaction):
//   - FSM goes to IDLE; the latched request is discarded.
//   - All outputs go to 0 except stall, which follows its equation.
//   - The memory is reset by the same rst.
// CONFIGURATION
//  ARB_RR_EN defined:
//   - Round-robin priority: after a completed data access, the next simultaneous conflict goes to fetch, and vice versa.
//   - A 1-bit last-winner register resets to "fetch", so the first conflict goes to data.
//  ARB_RR_EN undefined: fixed data-over-fetch priority; no last-winner register.
// STRUCTURE
//  Shared package cpu_mem_pkg:
//   - arb_state_t, the enum of the 5 states.
//   - mem_req_t, a packed struct {we, addr, wdata, be}.
//   - BE_ALL = '1, the read byte enable.
//  One sub-module, mem_req_latch: a capture register for mem_req_t, with load enable and async reset.
//  Mux, FSM and handshake pulses live in this module.
// TESTING
//  1. Fetch only: if_req=1, if_addr=0x0000_0010; m_gnt tied 1; m_rvalid one cycle after the grant with m_rdata=0x0050_0093.
//     -> if_gnt at cycle 0; m_req at cycle 1; if_rvalid with if_rdata=0x0050_0093 at cycle 2.
//  2. Store: d_req=1, d_we=1, d_addr=0x0000_0104, d_wdata=0xDEAD_BEEF, d_be=4'b0011.
//     -> m_we=1, m_be=4'b0011, m_addr=0x104; d_done pulses; d_rdata=0.
//  3. Conflict: if_req and d_req asserted in the same cycle, load from 0x200.
//     -> d_gnt first.
//     -> without ARB_RR_EN: if_gnt only after d_done plus 1 cycle.
//     -> with ARB_RR_EN: a second conflict goes to fetch.
//  4. Memory backpressure: m_gnt low for 5 cycles.
//     -> m_req and m_addr held stable for 5 cycles; stall=1 throughout; no gnt pulse repeats.
//  5. Reset in WAIT_D: rst pulse, then m_rvalid=1.
//     -> no d_done; outputs 0; FSM in IDLE.
//  6. Stray m_rvalid in IDLE with m_rdata=0x1234.
//     -> no if_rvalid or d_done; state unchanged.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared types for the unified-memory port arbiter: arbiter FSM
//             states, captured memory request record and read byte enable.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_mem_pkg;

    // The request record is sized here, so the arbiter's WIDTH/BE_W must match
    localparam int MEM_WIDTH = 32;
    localparam int MEM_BE_W  = MEM_WIDTH / 8;

    // Byte enable presented to memory for every read (fetch or load)
    localparam logic [MEM_BE_W-1:0] BE_ALL = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic                 we;
        logic [MEM_WIDTH-1:0] addr;
        logic [MEM_WIDTH-1:0] wdata;
        logic [MEM_BE_W-1:0]  be;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_latch.sv
// ============================================================================
//  Module   : mem_req_latch
//  Purpose  : Capture register for one memory request record; holds the
//             fields stable while the memory port is busy.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_latch
    import cpu_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  mem_req_t d,
    output mem_req_t q
);

    // Load a new request when the arbiter grants one; cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between instruction fetch and
//             load/store access, one outstanding transaction at a time.
//             Optional macro ARB_RR_EN: round-robin priority on conflicts
//             instead of fixed data-over-fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH,  // must equal MEM_WIDTH of cpu_mem_pkg
    parameter int BE_W  = MEM_BE_W    // must equal WIDTH/8
) (
    input  logic             clk,
    input  logic             rst,
    // fetch side
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,
    // load/store side
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [BE_W-1:0]  d_be,
    output logic             d_gnt,
    output logic             d_done,
    output logic [WIDTH-1:0] d_rdata,
    // memory side
    output logic             m_req,
    output logic             m_we,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    output logic [BE_W-1:0]  m_be,
    input  logic             m_gnt,
    input  logic             m_rvalid,
    input  logic [WIDTH-1:0] m_rdata,
    // pipeline freeze
    output logic             stall
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    mem_req_t   w_req_new;
    mem_req_t   r_req;
    logic       w_idle;
    logic       w_data_first;
    logic       w_take_d;
    logic       w_take_i;
    logic       w_resp;

    assign w_idle = (r_state == IDLE);
    assign w_resp = ((r_state == WAIT_I) || (r_state == WAIT_D)) && m_rvalid;

`ifdef ARB_RR_EN
    logic r_last_data;

    // Track who completed last; a conflict then goes to the other requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_data <= 1'b0;
        end else if (w_resp) begin
            r_last_data <= (r_state == WAIT_D);
        end
    end

    assign w_data_first = ~r_last_data;
`else
    assign w_data_first = 1'b1;
`endif

    // Requests are only captured in IDLE; reset suppresses the grant pulses
    assign w_take_d = w_idle & ~rst & d_req & (w_data_first | ~if_req);
    assign w_take_i = w_idle & ~rst & if_req & ~w_take_d;

    // Select the fields of the winning requester for capture
    always_comb begin
        w_req_new    = '0;
        w_req_new.be = BE_ALL;
        if (w_take_d) begin
            w_req_new.we   = d_we;
            w_req_new.addr = d_addr;
            if (d_we) begin
                w_req_new.wdata = d_wdata;
                w_req_new.be    = d_be;
            end
        end else begin
            w_req_new.addr = if_addr;
        end
    end

    mem_req_latch u_req_latch (
        .clk  (clk),
        .rst  (rst),
        .load (w_take_d | w_take_i),
        .d    (w_req_new),
        .q    (r_req)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake pulses
    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = w_take_i;
        d_gnt       = w_take_d;
        m_req       = 1'b0;
        if_rvalid   = 1'b0;
        d_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take_d) begin
                    w_state_nxt = REQ_D;
                end else if (w_take_i) begin
                    w_state_nxt = REQ_I;
                end
            end
            REQ_I: begin
                m_req = 1'b1;
                if (m_gnt) begin
                    w_state_nxt = WAIT_I;
                end
            end
            REQ_D: begin
                m_req = 1'b1;
                if (m_gnt) begin
                    w_state_nxt = WAIT_D;
                end
            end
            WAIT_I: begin
                if (m_rvalid) begin
                    if_rvalid   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_D: begin
                if (m_rvalid) begin
                    d_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m_we    = r_req.we;
    assign m_addr  = r_req.addr;
    assign m_wdata = r_req.wdata;
    assign m_be    = r_req.be;

    // Read data is only passed through in the response cycle
    assign if_rdata = if_rvalid ? m_rdata : '0;
    assign d_rdata  = d_done    ? m_rdata : '0;

    assign stall = (if_req & ~if_rvalid) | (d_req & ~d_done);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: transaction-level
//             reference model compared every cycle plus directed literals.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        stall;

    // memory responder controls
    logic auto_resp;
    logic resp_r;
    logic man_rv;
    logic acc;

    int checks = 0;
    int passes = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Memory stand-in: answers one cycle after accepting a request
    always @(posedge clk) begin
        acc = m_req && m_gnt;
        #1;
        resp_r = acc && !rst;
    end
    assign m_rvalid = auto_resp ? resp_r : man_rv;

    // ---------------- reference model (transaction level) -----------------
    logic        t_valid, t_issued, t_is_d, t_we, last_data;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_be;

    initial begin
        t_valid = 0; t_issued = 0; t_is_d = 0; t_we = 0; last_data = 0;
        t_addr = 0; t_wdata = 0; t_be = 0;
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin : model_blk
        logic        dfirst, take_d, take_i, e_mreq, resp, e_irv, e_dd;
        logic [31:0] e_ird, e_drd;
        if (rst) begin
            chk("rst if_gnt", if_gnt, 0);
            chk("rst d_gnt", d_gnt, 0);
            chk("rst if_rvalid", if_rvalid, 0);
            chk("rst d_done", d_done, 0);
            chk("rst if_rdata", if_rdata, 0);
            chk("rst d_rdata", d_rdata, 0);
            chk("rst m_req", m_req, 0);
            chk("rst m_we", m_we, 0);
            chk("rst m_addr", m_addr, 0);
            chk("rst m_wdata", m_wdata, 0);
            chk("rst m_be", m_be, 0);
            chk("rst stall", stall, if_req | d_req);
            t_valid = 0; t_issued = 0; last_data = 0;
        end else begin
            dfirst = 1'b1;
`ifdef ARB_RR_EN
            dfirst = !last_data;
`endif
            take_d = !t_valid && d_req && (dfirst || !if_req);
            take_i = !t_valid && if_req && !take_d;
            e_mreq = t_valid && !t_issued;
            resp   = t_valid && t_issued && m_rvalid;
            e_irv  = resp && !t_is_d;
            e_dd   = resp && t_is_d;
            e_ird  = e_irv ? m_rdata : 32'h0;
            e_drd  = e_dd ? m_rdata : 32'h0;
            chk("if_gnt", if_gnt, take_i);
            chk("d_gnt", d_gnt, take_d);
            chk("if_rvalid", if_rvalid, e_irv);
            chk("d_done", d_done, e_dd);
            chk("if_rdata", if_rdata, e_ird);
            chk("d_rdata", d_rdata, e_drd);
            chk("m_req", m_req, e_mreq);
            chk("stall", stall, (if_req & ~e_irv) | (d_req & ~e_dd));
            if (e_mreq) begin
                chk("m_we", m_we, t_we);
                chk("m_addr", m_addr, t_addr);
                chk("m_be", m_be, t_be);
                if (t_we) chk("m_wdata", m_wdata, t_wdata);
            end
            if (resp) begin
                t_valid = 0;
                last_data = t_is_d;
            end else if (e_mreq && m_gnt) begin
                t_issued = 1;
            end else if (take_d) begin
                t_valid = 1; t_issued = 0; t_is_d = 1; t_we = d_we;
                t_addr = d_addr; t_wdata = d_wdata; t_be = d_we ? d_be : 4'hF;
            end else if (take_i) begin
                t_valid = 1; t_issued = 0; t_is_d = 0; t_we = 0;
                t_addr = if_addr; t_wdata = 0; t_be = 4'hF;
            end
        end
    end

    // Run requesters until both are served; drop each req on its response
    task automatic drain(input string tag);
        logic si, sd;
        for (int n = 0; n < 40 && (if_req || d_req); n++) begin
            si = if_rvalid;
            sd = d_done;
            adv();
            if (si) if_req = 0;
            if (sd) d_req = 0;
            if (if_req || d_req) mid();
        end
        chk($sformatf("%s drain", tag), {31'b0, if_req | d_req}, 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; m_gnt = 1; m_rdata = 0;
        auto_resp = 1; resp_r = 0; man_rv = 0; acc = 0;

        // reset: requests ignored, stall follows its equation
        adv(); d_req = 1;
        mid(); chk("L rst d_gnt", d_gnt, 0); chk("L rst stall", stall, 1);
        chk("L rst m_req", m_req, 0);
        adv(); d_req = 0; rst = 0;
        mid(); chk("L idle stall", stall, 0);

        // store
        adv(); d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF;
        d_be = 4'b0011; m_rdata = 0;
        mid(); chk("L st d_gnt", d_gnt, 1); chk("L st stall", stall, 1);
        adv(); mid();
        chk("L st m_req", m_req, 1); chk("L st m_we", m_we, 1);
        chk("L st m_be", m_be, 4'b0011); chk("L st m_addr", m_addr, 32'h104);
        chk("L st m_wdata", m_wdata, 32'hDEAD_BEEF);
        adv(); mid(); chk("L st d_done", d_done, 1); chk("L st d_rdata", d_rdata, 0);
        adv(); d_req = 0; d_we = 0;

        // fetch only
        if_req = 1; if_addr = 32'h10; m_rdata = 32'h0050_0093;
        mid(); chk("L f if_gnt c0", if_gnt, 1);
        adv(); mid();
        chk("L f m_req c1", m_req, 1); chk("L f m_addr", m_addr, 32'h10);
        chk("L f m_be", m_be, 4'hF); chk("L f m_we", m_we, 0);
        adv(); mid();
        chk("L f if_rvalid c2", if_rvalid, 1); chk("L f if_rdata", if_rdata, 32'h0050_0093);
        chk("L f stall c2", stall, 0);
        adv(); if_req = 0;

        // conflict: data first, fetch one cycle after d_done
        if_req = 1; if_addr = 32'h20; d_req = 1; d_addr = 32'h200; m_rdata = 32'h1111_2222;
        mid(); chk("L c1 d_gnt", d_gnt, 1); chk("L c1 if_gnt", if_gnt, 0);
        adv(); mid(); chk("L c1 m_addr", m_addr, 32'h200);
        adv(); mid(); chk("L c1 d_done", d_done, 1); chk("L c1 d_rdata", d_rdata, 32'h1111_2222);
        chk("L c1 no if_gnt", if_gnt, 0);
        adv(); d_req = 0; m_rdata = 32'h0000_0013;
        mid(); chk("L c1 if_gnt late", if_gnt, 1);
        drain("conflict1");

        // second conflict right after a data completion
        if_req = 1; if_addr = 32'h24; d_req = 1; d_addr = 32'h208; m_rdata = 32'h2222_3333;
        mid(); chk("L c2 d_gnt", d_gnt, 1);
        adv(); mid(); adv(); mid(); chk("L c2 d_done", d_done, 1);
        adv(); d_addr = 32'h20C;
        mid();
`ifdef ARB_RR_EN
        chk("L c2 rr if_gnt", if_gnt, 1); chk("L c2 rr d_gnt", d_gnt, 0);
`else
        chk("L c2 fix d_gnt", d_gnt, 1); chk("L c2 fix if_gnt", if_gnt, 0);
`endif
        drain("conflict2");

        // memory backpressure
        m_gnt = 0; if_req = 1; if_addr = 32'h40;
        mid(); chk("L bp if_gnt", if_gnt, 1);
        for (int i = 0; i < 5; i++) begin
            adv(); mid();
            chk("L bp m_req", m_req, 1); chk("L bp m_addr", m_addr, 32'h40);
            chk("L bp stall", stall, 1); chk("L bp no regnt", if_gnt, 0);
        end
        adv(); m_gnt = 1;
        mid(); chk("L bp m_req gnt", m_req, 1);
        drain("backpressure");

        // reset while waiting for a load response
        auto_resp = 0; d_req = 1; d_we = 0; d_addr = 32'h300;
        mid(); chk("L r d_gnt", d_gnt, 1);
        adv(); mid();
        adv(); mid(); chk("L r wait m_req", m_req, 0); chk("L r wait d_done", d_done, 0);
        adv(); rst = 1;
        mid(); chk("L r m_addr", m_addr, 0); chk("L r stall", stall, 1);
        adv(); rst = 0; d_req = 0; man_rv = 1; m_rdata = 32'h5555_AAAA;
        mid(); chk("L r no d_done", d_done, 0); chk("L r d_rdata", d_rdata, 0);
        adv(); man_rv = 0;

        // stray response in IDLE
        man_rv = 1; m_rdata = 32'h1234;
        mid(); chk("L s if_rvalid", if_rvalid, 0); chk("L s d_done", d_done, 0);
        chk("L s if_rdata", if_rdata, 0);
        adv(); man_rv = 0; auto_resp = 1; if_req = 1; if_addr = 32'h50;
        mid(); chk("L s still idle", if_gnt, 1);
        drain("after stray");

        adv(); adv();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
